// File: rtl/ls_sequencer.sv
// Load/store sequencer between the multicycle control unit and word-addressed data memory.
// Sequences reads with a fixed latency, aligns load words and performs read-modify-write for sb/sh.
module ls_sequencer #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  dlrcontrol,
  output logic [31:0] mdr,
  output logic        busy,
  output logic        done,
  output logic        misalign
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg;
  logic [2:0]  op_reg;
  logic [1:0]  off_reg;
  logic [15:0] wdata_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wdata_reg;
  logic [31:0] mdr_reg;
  logic [1:0]  dlr_reg;

  logic        bad_align;
  logic        last_rd;
  logic [31:0] merged;
  logic [31:0] shifted;

  assign bad_align = (op[1:0] == 2'b11) ||
                     (op[1:0] == 2'b01 && addr[0]) ||
                     (op[1:0] == 2'b10 && addr[1:0] != 2'b00);

  assign last_rd = (cnt_reg <= 3'd1);

  // Load alignment: the addressed byte/half moves down to bit 0, zero-filled above.
  assign shifted = mem_rdata >> {off_reg, 3'b000};

  // Store merge: each byte lane takes either new store data or the word just read.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic hit;
      assign hit = (op_reg[1:0] == 2'b00) ? (off_reg == LANE) : (off_reg[1] == LANE[1]);
      assign merged[8*gi +: 8] = hit ? (op_reg[0] ? wdata_reg[8*(gi%2) +: 8] : wdata_reg[7:0])
                                     : mem_rdata[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (bad_align) begin
            state_next = ERR;
          end else if (op == 3'b110) begin
            state_next = WRITE;
          end else begin
            state_next = READ;
          end
        end
      end
      READ: begin
        if (last_rd) begin
          state_next = op_reg[2] ? WRITE : DONE;
        end
      end
      WRITE:   state_next = DONE;
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg       <= 3'd0;
      op_reg        <= 3'd0;
      off_reg       <= 2'd0;
      wdata_reg     <= 16'd0;
      mem_addr_reg  <= 32'd0;
      mem_wdata_reg <= 32'd0;
      mdr_reg       <= 32'd0;
      dlr_reg       <= 2'b10;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_reg       <= op;
            off_reg      <= addr[1:0];
            wdata_reg    <= wdata[15:0];
            mem_addr_reg <= {addr[31:2], 2'b00};
            cnt_reg      <= (state_next == READ) ? LAT : 3'd0;
            if (state_next == WRITE) begin
              mem_wdata_reg <= wdata;
            end
          end
        end
        READ: begin
          cnt_reg <= (cnt_reg != 3'd0) ? cnt_reg - 3'd1 : 3'd0;
          if (last_rd) begin
            if (op_reg[2]) begin
              mem_wdata_reg <= merged;
            end else begin
              mdr_reg <= shifted;
              dlr_reg <= op_reg[1:0];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign mdr        = mdr_reg;
  assign dlrcontrol = dlr_reg;
  assign mem_wr     = (state_reg == WRITE);
  assign busy       = (state_reg != IDLE);
  assign done       = (state_reg == DONE) || (state_reg == ERR);
  assign misalign   = (state_reg == ERR);

endmodule

// File: tb/tb_ls_sequencer.sv
// Self-checking bench for ls_sequencer: directed scenarios plus randomized accesses
// checked against a byte-level behavioural model of the load/store rules.
module tb_ls_sequencer;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [1:0]  dlrcontrol;
  logic [31:0] mdr;
  logic        busy;
  logic        done;
  logic        misalign;

  ls_sequencer #(.MEM_LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .addr       (addr),
    .wdata      (wdata),
    .mem_rdata  (mem_rdata),
    .mem_addr   (mem_addr),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .dlrcontrol (dlrcontrol),
    .mdr        (mdr),
    .busy       (busy),
    .done       (done),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  logic [31:0] exp_mdr;
  logic [1:0]  exp_dlr;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          done_cyc;
    bit          mis;
    bit          mis_stray;
    bit          busy_low;
    bit          idle_busy;
    bit          idle_done;
    int          wr_cnt;
    int          wr_cyc;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [31:0] rd_addr;
    logic [31:0] mdr;
    logic [1:0]  dlr;
  } obs_t;

  typedef struct {
    bit          mis;
    bit          reads;
    int          done_cyc;
    int          wr_cyc;
    logic [31:0] wr_data;
    logic [31:0] new_mdr;
  } exp_t;

  // Behavioural model: outcome of one access given the old memory word.
  function automatic exp_t ref_access(input logic [2:0] o, input logic [31:0] a,
                                      input logic [31:0] w, input logic [31:0] old);
    exp_t e;
    int nb;
    int off;
    logic [7:0] b [4];
    nb  = 1 << o[1:0];
    off = int'(a[1:0]);
    e.mis = (o[1:0] == 2'b11) || ((off % nb) != 0);
    e.reads = 1'b0;
    e.wr_cyc = -1;
    e.wr_data = 32'h0;
    e.new_mdr = 32'h0;
    e.done_cyc = 1;
    if (!e.mis) begin
      if (o[2] && nb == 4) begin
        e.done_cyc = 2;
        e.wr_cyc = 1;
        e.wr_data = w;
      end else begin
        e.reads = 1'b1;
        if (o[2]) begin
          for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
          for (int i = 0; i < nb; i++) b[off+i] = w[8*i +: 8];
          e.wr_data = {b[3], b[2], b[1], b[0]};
          e.wr_cyc = LAT + 1;
          e.done_cyc = LAT + 2;
        end else begin
          e.new_mdr = old >> (8 * off);
          e.done_cyc = LAT + 1;
        end
      end
    end
    return e;
  endfunction

  // Issues one request at the next negedge and observes it until done (bounded).
  task automatic run_access(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                            input bit hold, output obs_t ob);
    ob = '{default: 0};
    ob.done_cyc = -1;
    ob.wr_cyc = -1;
    @(negedge clk);
    ob.idle_busy = busy;
    ob.idle_done = done;
    start = 1'b1;
    op = o;
    addr = a;
    wdata = w;
    mem_rdata = $urandom;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (!busy) ob.busy_low = 1'b1;
      if (misalign && !done) ob.mis_stray = 1'b1;
      if (c == LAT) ob.rd_addr = mem_addr;
      if (mem_wr) begin
        ob.wr_cnt++;
        ob.wr_cyc = c;
        ob.wr_addr = mem_addr;
        ob.wr_data = mem_wdata;
        mem[mem_addr[11:2]] = mem_wdata;
      end
      if (hold) begin
        start = 1'b1;
        op = 3'($urandom);
        addr = $urandom;
        wdata = $urandom;
      end else begin
        start = 1'b0;
      end
      mem_rdata = (c == LAT) ? mem[a[11:2]] : $urandom;
      if (done) begin
        ob.done_cyc = c;
        ob.mis = misalign;
        ob.mdr = mdr;
        ob.dlr = dlrcontrol;
        break;
      end
    end
    $display("[TB] access op=%b addr=%h wdata=%h hold=%0d -> done@%0d mis=%0d wr=%0d@%0d data=%h mdr=%h dlr=%b",
             o, a, w, hold, ob.done_cyc, ob.mis, ob.wr_cnt, ob.wr_cyc, ob.wr_data, ob.mdr, ob.dlr);
  endtask

  task automatic test_reset();
    obs_t ob;
    logic [77:0] rst_vec;
    rst_vec = {32'h0, 32'h0, 32'h0, 2'b10, 4'b0000};
    #12;
    n_tests++;
    if ({mem_addr, mem_wdata, mdr, dlrcontrol, mem_wr, busy, done, misalign} !== rst_vec) begin
      n_fail++;
      $display("FAIL reset_initial: got %h want %h",
               {mem_addr, mem_wdata, mdr, dlrcontrol, mem_wr, busy, done, misalign}, rst_vec);
    end
    @(negedge clk);
    reset = 1'b0;
    mem[10'h100] = 32'h0BADF00D;
    @(negedge clk);
    start = 1'b1; op = 3'b101; addr = 32'h402; wdata = 32'h00004321;
    @(negedge clk);
    start = 1'b0; mem_rdata = $urandom;
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_pre_busy: got %b want 1", busy); end
    @(negedge clk);
    mem_rdata = mem[10'h100];
    @(negedge clk);
    n_tests++;
    if (mem_wr !== 1'b1) begin n_fail++; $display("FAIL reset_pre_write: got %b want 1", mem_wr); end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({mem_addr, mem_wdata, mdr, dlrcontrol, mem_wr, busy, done, misalign} !== rst_vec) begin
      n_fail++;
      $display("FAIL reset_mid_write: got %h want %h",
               {mem_addr, mem_wdata, mdr, dlrcontrol, mem_wr, busy, done, misalign}, rst_vec);
    end
    $display("[TB] reset asserted mid-write, outputs checked");
    @(negedge clk);
    reset = 1'b0;
    mem[10'h140] = 32'h600DCAFE;
    run_access(3'b010, 32'h500, 32'h0, 1'b0, ob);
    n_tests++;
    if (ob.done_cyc !== LAT + 1) begin n_fail++; $display("FAIL reset_release_done: got %0d want %0d", ob.done_cyc, LAT + 1); end
    n_tests++;
    if (ob.mdr !== 32'h600DCAFE) begin n_fail++; $display("FAIL reset_release_mdr: got %h want 600dcafe", ob.mdr); end
    exp_mdr = 32'h600DCAFE;
    exp_dlr = 2'b10;
  endtask

  task automatic test_lb();
    obs_t ob;
    mem[10'h040] = 32'hAABBCCDD;
    run_access(3'b000, 32'h103, 32'h12345678, 1'b0, ob);
    n_tests++;
    if (ob.rd_addr !== 32'h100) begin n_fail++; $display("FAIL lb_mem_addr: got %h want 00000100", ob.rd_addr); end
    n_tests++;
    if (ob.done_cyc !== 3) begin n_fail++; $display("FAIL lb_done_cycle: got %0d want 3", ob.done_cyc); end
    n_tests++;
    if (ob.mdr !== 32'h000000AA) begin n_fail++; $display("FAIL lb_mdr: got %h want 000000aa", ob.mdr); end
    n_tests++;
    if (ob.dlr !== 2'b00) begin n_fail++; $display("FAIL lb_dlrcontrol: got %b want 00", ob.dlr); end
    n_tests++;
    if (ob.wr_cnt !== 0) begin n_fail++; $display("FAIL lb_no_write: got %0d writes want 0", ob.wr_cnt); end
    exp_mdr = 32'h000000AA;
    exp_dlr = 2'b00;
  endtask

  task automatic test_sh();
    obs_t ob;
    mem[10'h080] = 32'h11223344;
    run_access(3'b101, 32'h202, 32'h12345678, 1'b0, ob);
    n_tests++;
    if (ob.wr_cnt !== 1 || ob.wr_cyc !== 3) begin n_fail++; $display("FAIL sh_write_cycle: got %0d writes at %0d want 1 at 3", ob.wr_cnt, ob.wr_cyc); end
    n_tests++;
    if (ob.wr_data !== 32'h56783344) begin n_fail++; $display("FAIL sh_wdata: got %h want 56783344", ob.wr_data); end
    n_tests++;
    if (ob.wr_addr !== 32'h200) begin n_fail++; $display("FAIL sh_waddr: got %h want 00000200", ob.wr_addr); end
    n_tests++;
    if (ob.done_cyc !== 4) begin n_fail++; $display("FAIL sh_done_cycle: got %0d want 4", ob.done_cyc); end
    n_tests++;
    if (ob.mdr !== exp_mdr || ob.dlr !== exp_dlr) begin n_fail++; $display("FAIL sh_mdr_held: got %h/%b want %h/%b", ob.mdr, ob.dlr, exp_mdr, exp_dlr); end
  endtask

  task automatic test_sw();
    obs_t ob;
    run_access(3'b110, 32'h300, 32'hDEADBEEF, 1'b0, ob);
    n_tests++;
    if (ob.wr_cnt !== 1 || ob.wr_cyc !== 1) begin n_fail++; $display("FAIL sw_write_cycle: got %0d writes at %0d want 1 at 1", ob.wr_cnt, ob.wr_cyc); end
    n_tests++;
    if (ob.wr_data !== 32'hDEADBEEF || ob.wr_addr !== 32'h300) begin n_fail++; $display("FAIL sw_write: got %h@%h want deadbeef@00000300", ob.wr_data, ob.wr_addr); end
    n_tests++;
    if (ob.done_cyc !== 2) begin n_fail++; $display("FAIL sw_done_cycle: got %0d want 2", ob.done_cyc); end
    n_tests++;
    if (ob.mdr !== exp_mdr || ob.dlr !== exp_dlr) begin n_fail++; $display("FAIL sw_mdr_held: got %h/%b want %h/%b", ob.mdr, ob.dlr, exp_mdr, exp_dlr); end
  endtask

  task automatic test_misalign();
    obs_t ob;
    logic [2:0]  ops [2];
    logic [31:0] adrs [2];
    ops[0] = 3'b010; adrs[0] = 32'h302;
    ops[1] = 3'b011; adrs[1] = 32'h304;
    for (int k = 0; k < 2; k++) begin
      run_access(ops[k], adrs[k], 32'h0, 1'b0, ob);
      n_tests++;
      if (ob.done_cyc !== 1 || ob.mis !== 1'b1) begin n_fail++; $display("FAIL misalign_%0d_done: got done@%0d mis=%b want done@1 mis=1", k, ob.done_cyc, ob.mis); end
      n_tests++;
      if (ob.wr_cnt !== 0) begin n_fail++; $display("FAIL misalign_%0d_no_write: got %0d writes want 0", k, ob.wr_cnt); end
      n_tests++;
      if (ob.mdr !== exp_mdr || ob.dlr !== exp_dlr) begin n_fail++; $display("FAIL misalign_%0d_mdr_held: got %h/%b want %h/%b", k, ob.mdr, ob.dlr, exp_mdr, exp_dlr); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t ob;
    mem[10'h03F] = 32'hCAFEF00D;
    mem[10'h03E] = 32'h13579BDF;
    run_access(3'b001, 32'h0FE, 32'h0, 1'b1, ob);
    n_tests++;
    if (ob.done_cyc !== 3 || ob.busy_low !== 1'b0) begin n_fail++; $display("FAIL b2b_lh_done: got done@%0d busy_low=%b want done@3 busy_low=0", ob.done_cyc, ob.busy_low); end
    n_tests++;
    if (ob.mdr !== 32'h0000CAFE || ob.dlr !== 2'b01) begin n_fail++; $display("FAIL b2b_lh_mdr: got %h/%b want 0000cafe/01", ob.mdr, ob.dlr); end
    run_access(3'b010, 32'h0F8, 32'h0, 1'b0, ob);
    n_tests++;
    if (ob.idle_busy !== 1'b0 || ob.idle_done !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after_done: got busy=%b done=%b want 0/0", ob.idle_busy, ob.idle_done); end
    n_tests++;
    if (ob.done_cyc !== 3) begin n_fail++; $display("FAIL b2b_next_accept: got done@%0d want done@3", ob.done_cyc); end
    n_tests++;
    if (ob.mdr !== 32'h13579BDF || ob.dlr !== 2'b10) begin n_fail++; $display("FAIL b2b_lw_mdr: got %h/%b want 13579bdf/10", ob.mdr, ob.dlr); end
    exp_mdr = 32'h13579BDF;
    exp_dlr = 2'b10;
  endtask

  task automatic test_random();
    obs_t ob;
    exp_t e;
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] w;
    bit hold;
    for (int i = 0; i < 60; i++) begin
      o[2] = 1'($urandom);
      o[1:0] = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (o[1:0] == 2'b01) a[0] = 1'b0;
        if (o[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      w = $urandom;
      hold = ($urandom_range(0, 3) == 0);
      e = ref_access(o, a, w, mem[a[11:2]]);
      run_access(o, a, w, hold, ob);
      if (!e.mis && e.reads && !o[2]) begin
        exp_mdr = e.new_mdr;
        exp_dlr = o[1:0];
      end
      n_tests++;
      if (ob.done_cyc !== e.done_cyc || ob.mis !== e.mis) begin n_fail++; $display("FAIL rand%0d_done: got done@%0d mis=%b want done@%0d mis=%b", i, ob.done_cyc, ob.mis, e.done_cyc, e.mis); end
      n_tests++;
      if (ob.mis_stray || ob.busy_low || ob.idle_busy || ob.idle_done) begin n_fail++; $display("FAIL rand%0d_flags: got stray=%b busy_low=%b idle_busy=%b idle_done=%b want all 0", i, ob.mis_stray, ob.busy_low, ob.idle_busy, ob.idle_done); end
      n_tests++;
      if (ob.wr_cnt !== ((e.wr_cyc >= 0) ? 1 : 0) || ob.wr_cyc !== e.wr_cyc) begin n_fail++; $display("FAIL rand%0d_wr_timing: got %0d writes at %0d want at %0d", i, ob.wr_cnt, ob.wr_cyc, e.wr_cyc); end
      if (e.wr_cyc >= 0) begin
        n_tests++;
        if (ob.wr_data !== e.wr_data || ob.wr_addr !== {a[31:2], 2'b00}) begin n_fail++; $display("FAIL rand%0d_wr_data: got %h@%h want %h@%h", i, ob.wr_data, ob.wr_addr, e.wr_data, {a[31:2], 2'b00}); end
      end
      if (e.reads) begin
        n_tests++;
        if (ob.rd_addr !== {a[31:2], 2'b00}) begin n_fail++; $display("FAIL rand%0d_rd_addr: got %h want %h", i, ob.rd_addr, {a[31:2], 2'b00}); end
      end
      n_tests++;
      if (ob.mdr !== exp_mdr || ob.dlr !== exp_dlr) begin n_fail++; $display("FAIL rand%0d_mdr: got %h/%b want %h/%b", i, ob.mdr, ob.dlr, exp_mdr, exp_dlr); end
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        start = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op = 3'b000;
    addr = 32'h0;
    wdata = 32'h0;
    mem_rdata = 32'h0;
    exp_mdr = 32'h0;
    exp_dlr = 2'b10;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    test_reset();
    test_lb();
    test_sh();
    test_sw();
    test_misalign();
    test_back_to_back();
    test_random();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
